// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched ALU instructions until their operands
// arrive over the CDB, then issues the lowest-index ready entry to the ALU.
module alu_rs #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           disp_valid,
    input  logic [9:0]                     disp_op,
    input  logic [TAG_W-1:0]               disp_Qj,
    input  logic [TAG_W-1:0]               disp_Qk,
    input  logic [31:0]                    disp_Vj,
    input  logic [31:0]                    disp_Vk,
    input  logic [TAG_W-1:0]               disp_tag,
    output logic                           full,
    input  logic                           cdb_valid,
    input  logic [TAG_W-1:0]               cdb_tag,
    input  logic [31:0]                    cdb_value,
    input  logic                           iss_ready,
    output logic                           iss_valid,
    output logic [31:0]                    iss_Vj,
    output logic [31:0]                    iss_Vk,
    output logic [9:0]                     iss_Op,
    output logic [TAG_W-1:0]               iss_tag,
    output logic [$clog2(ENTRIES+1)-1:0]   count
);

    localparam int CW = $clog2(ENTRIES + 1);
    localparam int IW = $clog2(ENTRIES);

    logic [ENTRIES-1:0] busy;
    logic [9:0]         op   [ENTRIES];
    logic [TAG_W-1:0]   qj   [ENTRIES];
    logic [TAG_W-1:0]   qk   [ENTRIES];
    logic [31:0]        vj   [ENTRIES];
    logic [31:0]        vk   [ENTRIES];
    logic [TAG_W-1:0]   dest [ENTRIES];

    logic          iss_hit;
    logic [IW-1:0] iss_idx;
    logic          alloc_hit;
    logic [IW-1:0] alloc_idx;
    logic [CW-1:0] occ;
    logic          cdb_live;
    logic          disp_fire;
    logic          iss_fire;

    // Selection and occupancy look only at registered state, so a slot freed by
    // issue this cycle is not visible to the allocator until the next cycle.
    always_comb begin
        iss_hit   = 1'b0;
        iss_idx   = '0;
        alloc_hit = 1'b0;
        alloc_idx = '0;
        occ       = '0;
        for (int unsigned i = ENTRIES; i > 0; i--) begin
            if (busy[i-1] && qj[i-1] == '0 && qk[i-1] == '0) begin
                iss_hit = 1'b1;
                iss_idx = IW'(i - 1);
            end
            if (!busy[i-1]) begin
                alloc_hit = 1'b1;
                alloc_idx = IW'(i - 1);
            end
            if (busy[i-1]) begin
                occ = occ + CW'(1);
            end
        end
    end

    assign count     = occ;
    assign full      = (occ == CW'(ENTRIES));
    assign cdb_live  = cdb_valid && (cdb_tag != '0);
    assign disp_fire = disp_valid && !full && alloc_hit;
    assign iss_fire  = iss_hit && iss_ready;

    always_comb begin
        iss_valid = iss_hit;
        iss_Vj    = '0;
        iss_Vk    = '0;
        iss_Op    = '0;
        iss_tag   = '0;
        if (iss_hit) begin
            iss_Vj  = vj[iss_idx];
            iss_Vk  = vk[iss_idx];
            iss_Op  = op[iss_idx];
            iss_tag = dest[iss_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                busy[i] <= 1'b0;
                op[i]   <= '0;
                qj[i]   <= '0;
                qk[i]   <= '0;
                vj[i]   <= '0;
                vk[i]   <= '0;
                dest[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (busy[i]) begin
                    if (cdb_live && qj[i] == cdb_tag) begin
                        qj[i] <= '0;
                        vj[i] <= cdb_value;
                    end
                    if (cdb_live && qk[i] == cdb_tag) begin
                        qk[i] <= '0;
                        vk[i] <= cdb_value;
                    end
                    if (iss_fire && iss_idx == IW'(i)) begin
                        busy[i] <= 1'b0;
                    end
                end else if (disp_fire && alloc_idx == IW'(i)) begin
                    busy[i] <= 1'b1;
                    op[i]   <= disp_op;
                    dest[i] <= disp_tag;
                    // Bypass a result broadcast in the same cycle as dispatch.
                    if (cdb_live && disp_Qj == cdb_tag) begin
                        qj[i] <= '0;
                        vj[i] <= cdb_value;
                    end else begin
                        qj[i] <= disp_Qj;
                        vj[i] <= disp_Vj;
                    end
                    if (cdb_live && disp_Qk == cdb_tag) begin
                        qk[i] <= '0;
                        vk[i] <= cdb_value;
                    end else begin
                        qk[i] <= disp_Qk;
                        vk[i] <= disp_Vk;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: reference model compared every negedge, plus
// directed scenarios with hand-computed literal expectations.
module tb_alu_rs;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_valid;
    logic [9:0]  disp_op;
    logic [3:0]  disp_Qj, disp_Qk, disp_tag;
    logic [31:0] disp_Vj, disp_Vk;
    logic        full;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_ready;
    logic        iss_valid;
    logic [31:0] iss_Vj, iss_Vk;
    logic [9:0]  iss_Op;
    logic [3:0]  iss_tag;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rs #(.ENTRIES(N), .TAG_W(4)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_Qj(disp_Qj), .disp_Qk(disp_Qk),
        .disp_Vj(disp_Vj), .disp_Vk(disp_Vk), .disp_tag(disp_tag),
        .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_ready(iss_ready), .iss_valid(iss_valid),
        .iss_Vj(iss_Vj), .iss_Vk(iss_Vk), .iss_Op(iss_Op), .iss_tag(iss_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a table of slots following the station's rules directly.
    bit          m_busy [N];
    logic [9:0]  m_op   [N];
    logic [3:0]  m_qj   [N];
    logic [3:0]  m_qk   [N];
    logic [3:0]  m_tg   [N];
    logic [31:0] m_vj   [N];
    logic [31:0] m_vk   [N];

    function automatic int m_first_ready();
        for (int i = 0; i < N; i++)
            if (m_busy[i] && m_qj[i] == 4'd0 && m_qk[i] == 4'd0) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    always @(posedge clk or posedge reset) begin
        int r, c, f;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0; m_op[i] = '0; m_qj[i] = '0; m_qk[i] = '0;
                m_tg[i] = '0; m_vj[i] = '0; m_vk[i] = '0;
            end
        end else begin
            r = m_first_ready();
            c = m_count();
            f = -1;
            if (disp_valid && c < N)
                for (int i = 0; i < N; i++) if (!m_busy[i]) begin f = i; break; end
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && cdb_valid && cdb_tag != 4'd0) begin
                    if (m_qj[i] == cdb_tag) begin m_qj[i] = 0; m_vj[i] = cdb_value; end
                    if (m_qk[i] == cdb_tag) begin m_qk[i] = 0; m_vk[i] = cdb_value; end
                end
            end
            if (r >= 0 && iss_ready) m_busy[r] = 0;
            if (f >= 0) begin
                m_busy[f] = 1; m_op[f] = disp_op; m_tg[f] = disp_tag;
                m_qj[f] = disp_Qj; m_vj[f] = disp_Vj;
                m_qk[f] = disp_Qk; m_vk[f] = disp_Vk;
                if (cdb_valid && cdb_tag != 4'd0 && disp_Qj == cdb_tag) begin
                    m_qj[f] = 0; m_vj[f] = cdb_value;
                end
                if (cdb_valid && cdb_tag != 4'd0 && disp_Qk == cdb_tag) begin
                    m_qk[f] = 0; m_vk[f] = cdb_value;
                end
            end
        end
    end

    always @(negedge clk) begin
        int r;
        r = m_first_ready();
        chk("model_count", 32'(count), m_count());
        chk("model_full", 32'(full), 32'(m_count() == N));
        chk("model_iss_valid", 32'(iss_valid), 32'(r >= 0));
        chk("model_iss_Vj", iss_Vj, (r >= 0) ? m_vj[r] : 32'd0);
        chk("model_iss_Vk", iss_Vk, (r >= 0) ? m_vk[r] : 32'd0);
        chk("model_iss_Op", 32'(iss_Op), (r >= 0) ? 32'(m_op[r]) : 32'd0);
        chk("model_iss_tag", 32'(iss_tag), (r >= 0) ? 32'(m_tg[r]) : 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0;
    endtask

    task automatic disp(input logic [9:0] o, input logic [3:0] qj, input logic [31:0] vj,
                        input logic [3:0] qk, input logic [31:0] vk, input logic [3:0] tg);
        disp_valid = 1; disp_op = o; disp_Qj = qj; disp_Vj = vj;
        disp_Qk = qk; disp_Vk = vk; disp_tag = tg;
    endtask

    initial begin
        reset = 1; disp_valid = 0; disp_op = '0; disp_Qj = '0; disp_Qk = '0;
        disp_Vj = '0; disp_Vk = '0; disp_tag = '0; cdb_valid = 0; cdb_tag = '0;
        cdb_value = '0; iss_ready = 0;
        #2;
        chk("reset_count", 32'(count), 0);
        chk("reset_full", 32'(full), 0);
        chk("reset_iss_valid", 32'(iss_valid), 0);
        chk("reset_iss_tag", 32'(iss_tag), 0);
        tick(); tick();
        reset = 0;
        tick();

        // Simple ready-at-dispatch instruction.
        iss_ready = 1;
        disp(10'd0, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
        tick(); idle();
        chk("r31_iss_valid", 32'(iss_valid), 1);
        chk("r31_iss_Vj", iss_Vj, 5);
        chk("r31_iss_Vk", iss_Vk, 7);
        chk("r31_iss_tag", 32'(iss_tag), 3);
        tick();
        chk("r31_count", 32'(count), 0);

        // CDB wakeup: ready only the cycle after the broadcast.
        disp(10'h15, 4'd2, 32'd0, 4'd0, 32'd1, 4'd4);
        tick(); idle();
        cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 32'h10;
        chk("r32_iss_valid_bcast", 32'(iss_valid), 0);
        tick(); idle();
        chk("r32_iss_valid", 32'(iss_valid), 1);
        chk("r32_iss_Vj", iss_Vj, 32'h10);
        chk("r32_iss_Op", 32'(iss_Op), 32'h15);
        tick();

        // Dispatch-time bypass.
        disp(10'd1, 4'd0, 32'h22, 4'd6, 32'd0, 4'd5);
        cdb_valid = 1; cdb_tag = 4'd6; cdb_value = 32'hAB;
        tick(); idle();
        chk("r33_iss_valid", 32'(iss_valid), 1);
        chk("r33_iss_Vk", iss_Vk, 32'hAB);
        chk("r33_iss_Vj", iss_Vj, 32'h22);
        tick();

        // Fill, reject when full, then in-order issue after one broadcast.
        iss_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            disp(10'(i), 4'd9, 32'd0, 4'd0, 32'(i * 16), 4'(i));
            tick();
        end
        chk("r34_full", 32'(full), 1);
        chk("r34_count", 32'(count), 4);
        disp(10'd7, 4'd0, 32'd1, 4'd0, 32'd1, 4'd7);
        tick(); idle();
        chk("r34_fifth_count", 32'(count), 4);
        chk("r34_fifth_iss_valid", 32'(iss_valid), 0);
        cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'h99;
        tick(); idle();
        iss_ready = 1;
        chk("r34_first_tag", 32'(iss_tag), 1);
        chk("r34_first_Vj", iss_Vj, 32'h99);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("r34_order_tag", 32'(iss_tag), 32'(i));
        end
        tick();
        chk("r34_drained", 32'(iss_valid), 0);

        // Full station: simultaneous issue and dispatch.
        iss_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            disp(10'd2, 4'd0, 32'(i), 4'd0, 32'd0, 4'(i));
            tick();
        end
        idle();
        chk("r35_full", 32'(full), 1);
        iss_ready = 1;
        disp(10'd3, 4'd0, 32'h80, 4'd0, 32'd0, 4'd8);
        tick();
        iss_ready = 0;
        chk("r35_count_after", 32'(count), 3);
        chk("r35_next_tag", 32'(iss_tag), 2);
        tick(); idle();
        chk("r35_count_accept", 32'(count), 4);
        chk("r35_freed_slot_tag", 32'(iss_tag), 8);

        // Asynchronous reset between edges.
        iss_ready = 1;
        tick();
        iss_ready = 0;
        chk("r36_count3", 32'(count), 3);
        #2 reset = 1;
        #1;
        chk("r36_async_count", 32'(count), 0);
        chk("r36_async_iss_valid", 32'(iss_valid), 0);
        chk("r36_async_full", 32'(full), 0);
        #1 reset = 0;
        disp(10'd4, 4'd0, 32'h11, 4'd0, 32'd0, 4'hA);
        tick();
        chk("r36_post_count", 32'(count), 1);
        disp(10'd5, 4'd0, 32'h12, 4'd0, 32'd0, 4'hB);
        tick(); idle();
        chk("r36_entry0_tag", 32'(iss_tag), 32'hA);
        chk("r36_entry0_Vj", iss_Vj, 32'h11);

        // Mixed traffic, checked against the model every cycle.
        for (int c = 0; c < 300; c++) begin
            disp_valid = 1'($urandom_range(0, 1));
            disp_op    = 10'($urandom);
            disp_Qj    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            disp_Qk    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            disp_Vj    = $urandom;
            disp_Vk    = $urandom;
            disp_tag   = 4'($urandom_range(1, 15));
            cdb_valid  = 1'($urandom_range(0, 1));
            cdb_tag    = 4'($urandom_range(1, 15));
            cdb_value  = $urandom;
            iss_ready  = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 Parameter ENTRIES, default 4, SHALL set the number of reservation-station entries (2..8).
REQ-002 Parameter TAG_W, default 4, SHALL set the producer-tag width; tag value 0 SHALL mean "operand already valid, no producer".
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 disp_valid  input  1  SHALL request dispatch of one instruction this cycle.
REQ-006 disp_op  input  10  SHALL carry the ALU opcode, passed unmodified to the ALU Op input.
REQ-007 disp_Qj, disp_Qk  input  TAG_W each  SHALL carry the producer tags of operands j and k.
REQ-008 disp_Vj, disp_Vk  input  32 each  SHALL carry the operand values, meaningful only where the matching Q is 0.
REQ-009 disp_tag  input  TAG_W  SHALL carry the destination tag of the dispatched instruction, nonzero.
REQ-010 full  output  1  SHALL be high when all entries are occupied.
REQ-011 cdb_valid  input  1, cdb_tag  input  TAG_W, cdb_value  input  32  SHALL form the common-data-bus result broadcast.
REQ-012 iss_ready  input  1  SHALL grant acceptance of the issued instruction by the ALU/CDB arbiter.
REQ-013 iss_valid  output  1  SHALL flag that iss_Vj, iss_Vk, iss_Op, iss_tag hold a ready instruction.
REQ-014 iss_Vj, iss_Vk  output  32, iss_Op  output  10, iss_tag  output  TAG_W  SHALL drive the ALU inputs and the result tag.
REQ-015 count  output  clog2(ENTRIES+1)  SHALL report the number of occupied entries.

Function
REQ-016 Each entry SHALL hold busy, op, Qj, Qk, Vj, Vk, dest tag.
REQ-017 Dispatch SHALL be accepted at a clock edge iff disp_valid=1 and full=0; disp_valid while full SHALL be ignored with no state change.
REQ-018 An accepted dispatch SHALL occupy the lowest-index non-busy entry, as computed from registered state.
REQ-019 An entry freed by issue in a cycle SHALL NOT be reallocated in that same cycle; it becomes available the following cycle.
REQ-020 On each edge with cdb_valid=1, every busy entry whose Qj (Qk) equals nonzero cdb_tag SHALL load Vj (Vk) with cdb_value and clear Qj (Qk) to 0.
REQ-021 Dispatch-time bypass: if cdb_valid=1 and disp_Qj (disp_Qk) equals nonzero cdb_tag in the accepting cycle, the new entry SHALL store cdb_value and Q=0.
REQ-022 An entry SHALL be ready when busy=1 and Qj=0 and Qk=0, evaluated on registered state only; a CDB wakeup makes it ready no earlier than the next cycle.
REQ-023 iss_valid SHALL be high iff any entry is ready; iss_* outputs SHALL reflect the lowest-index ready entry, and SHALL be 0 when iss_valid=0.
REQ-024 Issue SHALL complete at an edge where iss_valid=1 and iss_ready=1; that entry's busy SHALL clear at that edge.
REQ-025 iss_valid and iss_* SHALL be driven only from registered state, with no combinational path from disp_*, cdb_* or iss_ready.
REQ-026 count SHALL increment by 1 on accepted dispatch, decrement by 1 on issue, and stay unchanged when both occur together.
REQ-027 full SHALL equal (count == ENTRIES).
REQ-028 Behaviour for disp_tag=0 or cdb_tag=0 with cdb_valid=1 SHALL be undefined; cdb_tag 0 SHALL never match.

Reset
REQ-029 While reset=1, all entries SHALL be non-busy with all fields 0, and count=0, full=0, iss_valid=0, iss_Vj=iss_Vk=0, iss_Op=0, iss_tag=0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard all held instructions; the first edge after deassertion SHALL accept a dispatch.

Verification
REQ-031 Dispatch op=0, Qj=Qk=0, Vj=5, Vk=7, tag=3, iss_ready=1 -> next cycle iss_valid=1, iss_Vj=5, iss_Vk=7, iss_tag=3; following cycle count=0.
REQ-032 Dispatch Qj=2, Vk=1, Qk=0; then cdb_valid=1, tag=2, value=0x10 -> iss_valid=0 in broadcast cycle, iss_valid=1 with iss_Vj=0x10 the cycle after.
REQ-033 Dispatch with disp_Qk=6 in same cycle as cdb tag 6 value 0xAB -> entry ready next cycle with iss_Vk=0xAB.
REQ-034 Four dispatches with Qj=9, iss_ready=0 -> full=1, count=4; fifth disp_valid ignored; one CDB tag 9 -> entry 0 issued first, then 1, 2, 3.
REQ-035 Full RS, simultaneous issue and disp_valid -> dispatch rejected that cycle, count 3 after edge, accepted next cycle into freed index.
REQ-036 Three busy entries, reset pulsed between clock edges -> immediately count=0, iss_valid=0; dispatch on first post-reset edge lands in entry 0.
